// File: rtl/fb_alu_exec.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : fb_alu_exec                                                |
// | Description : Execute-stage ALU with valid/ready handshakes on both      |
// |               sides. Single-cycle ops finish in one cycle. Shifts run    |
// |               one bit per cycle so that no barrel shifter is needed.     |
// |               Result and branch-compare flags are registered and held    |
// |               stable under backpressure.                                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     issue stage presents an operation
//   in_ready     block accepts the operation this cycle
//   alu_control  one-hot op: [10]add [9]sub [8]sll [7]slt [6]sltu [5]xor
//                [4]srl [3]sra [2]or [1]and [0]branch (used with sub)
//   src_a/src_b  operands
//   out_valid    result valid
//   out_ready    downstream accepts the result
//   result       ALU result
//   zero         result == 0
//   lt / ltu     signed / unsigned src_a < src_b (branch only)
//   illegal      control word was not a legal encoding
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module fb_alu_exec #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [10:0]     alu_control,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            lt,
  output logic            ltu,
  output logic            illegal
);

  // Control word bit positions
  localparam int B_ADD  = 10;
  localparam int B_SUB  = 9;
  localparam int B_SLL  = 8;
  localparam int B_SLT  = 7;
  localparam int B_SLTU = 6;
  localparam int B_XOR  = 5;
  localparam int B_SRL  = 4;
  localparam int B_SRA  = 3;
  localparam int B_OR   = 2;
  localparam int B_AND  = 1;

  // The only legal two-hot word: branch compare carried on the subtractor
  localparam logic [10:0] C_BR_SUB = 11'b010_0000_0001;

  // Shift kind held while iterating
  localparam logic [1:0] SH_SLL = 2'd0;
  localparam logic [1:0] SH_SRL = 2'd1;
  localparam logic [1:0] SH_SRA = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state_q,   state_d;
  logic [XLEN-1:0]   result_q,  result_d;
  logic              zero_q,    zero_d;
  logic              lt_q,      lt_d;
  logic              ltu_q,     ltu_d;
  logic              illegal_q, illegal_d;
  logic [XLEN-1:0]   work_q,    work_d;
  logic [SHW-1:0]    cnt_q,     cnt_d;
  logic [1:0]        shop_q,    shop_d;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [9:0]      op_bits;
  logic            single_hot;
  logic            is_branch;
  logic            is_legal;
  logic            is_shift;
  logic [1:0]      shift_kind;
  logic [SHW-1:0]  shamt;
  logic            accept;

  assign op_bits    = alu_control[10:1];
  // Exactly one bit of [10:1] set: non-zero and clearing the lowest set bit leaves nothing
  assign single_hot = (op_bits != 10'd0) && ((op_bits & (op_bits - 10'd1)) == 10'd0)
                      && !alu_control[0];
  assign is_branch  = (alu_control == C_BR_SUB);
  assign is_legal   = single_hot || is_branch;
  assign is_shift   = single_hot &&
                      (alu_control[B_SLL] || alu_control[B_SRL] || alu_control[B_SRA]);
  assign shamt      = src_b[SHW-1:0];

  always_comb begin
    shift_kind = SH_SLL;
    if (alu_control[B_SRL]) shift_kind = SH_SRL;
    if (alu_control[B_SRA]) shift_kind = SH_SRA;
  end

  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;
  logic            slt_bit;
  logic            sltu_bit;
  logic [XLEN-1:0] alu_res;

  assign sum      = src_a + src_b;
  assign diff     = src_a - src_b;
  assign slt_bit  = $signed(src_a) < $signed(src_b);
  assign sltu_bit = src_a < src_b;

  always_comb begin
    alu_res = '0;
    if (is_branch)                              alu_res = diff;
    else if (single_hot) begin
      if (alu_control[B_ADD])                   alu_res = sum;
      if (alu_control[B_SUB])                   alu_res = diff;
      if (alu_control[B_SLT])                   alu_res = {{(XLEN-1){1'b0}}, slt_bit};
      if (alu_control[B_SLTU])                  alu_res = {{(XLEN-1){1'b0}}, sltu_bit};
      if (alu_control[B_XOR])                   alu_res = src_a ^ src_b;
      if (alu_control[B_OR])                    alu_res = src_a | src_b;
      if (alu_control[B_AND])                   alu_res = src_a & src_b;
      // A zero-distance shift completes immediately with src_a
      if (is_shift)                             alu_res = src_a;
    end
  end

  // One-bit step of the iterative shifter
  logic [XLEN-1:0] work_step;

  always_comb begin
    work_step = work_q;
    unique case (shop_q)
      SH_SLL:  work_step = {work_q[XLEN-2:0], 1'b0};
      SH_SRL:  work_step = {1'b0, work_q[XLEN-1:1]};
      SH_SRA:  work_step = {work_q[XLEN-1], work_q[XLEN-1:1]};
      default: work_step = work_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    lt_d      = lt_q;
    ltu_d     = ltu_q;
    illegal_d = illegal_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    shop_d    = shop_q;

    unique case (state_q)
      ST_SHIFT: begin
        work_d = work_step;
        cnt_d  = cnt_q - SHW'(1);
        // The last bit of shift is being applied this cycle
        if (cnt_q == SHW'(1)) begin
          result_d  = work_step;
          zero_d    = (work_step == '0);
          lt_d      = 1'b0;
          ltu_d     = 1'b0;
          illegal_d = 1'b0;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: ;
    endcase

    // Acceptance can only happen from IDLE or from a consumed DONE, so it
    // overrides whatever the state-specific branch chose above.
    if (accept) begin
      if (!is_legal) begin
        result_d  = '0;
        zero_d    = 1'b1;
        lt_d      = 1'b0;
        ltu_d     = 1'b0;
        illegal_d = 1'b1;
        state_d   = ST_DONE;
      end else if (is_shift && (shamt != '0)) begin
        work_d  = src_a;
        cnt_d   = shamt;
        shop_d  = shift_kind;
        state_d = ST_SHIFT;
      end else begin
        result_d  = alu_res;
        zero_d    = (alu_res == '0);
        lt_d      = is_branch && slt_bit;
        ltu_d     = is_branch && sltu_bit;
        illegal_d = 1'b0;
        state_d   = ST_DONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      lt_q      <= 1'b0;
      ltu_q     <= 1'b0;
      illegal_q <= 1'b0;
      work_q    <= '0;
      cnt_q     <= '0;
      shop_q    <= SH_SLL;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      lt_q      <= lt_d;
      ltu_q     <= ltu_d;
      illegal_q <= illegal_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      shop_q    <= shop_d;
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign lt        = lt_q;
  assign ltu       = ltu_q;
  assign illegal   = illegal_q;

endmodule

`default_nettype wire

// File: doc/fb_alu_exec.md
Name: fb_alu_exec

Overview:
- Execute-stage ALU. Consumes the 11-bit one-hot ALU control word and both operands, and produces a registered result plus branch-compare flags.
- Single-cycle ops complete in 1 cycle. Shifts run iteratively, 1 bit per cycle, to keep the barrel shifter off the critical path.
- Sits between the decode/issue pipeline register and the memory/writeback stage.
- Uses a valid/ready handshake on both sides so stalls propagate.

Parameters:
- XLEN, 32, operand/result width.
- SHW, $clog2(XLEN), shift-amount width (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  issue stage presents an operation.
- in_ready  output  1  block accepts the operation this cycle.
- alu_control  input  11  one-hot op: [10]add [9]sub [8]sll [7]slt [6]sltu [5]xor [4]srl [3]sra [2]or [1]and [0]branch.
- src_a  input  XLEN  operand A (rs1).
- src_b  input  XLEN  operand B (rs2 or immediate).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- result  output  XLEN  ALU result.
- zero  output  1  result == 0.
- lt  output  1  signed src_a < src_b (meaningful on branch).
- ltu  output  1  unsigned src_a < src_b (meaningful on branch).
- illegal  output  1  control word was not a legal encoding.

Behaviour:
- Reset (async, rst_n low): state IDLE; out_valid=0; result=0; zero, lt, ltu, illegal=0; shift counter=0. Outputs stay clean in every state at reset assertion, including reset asserted mid-shift.
- Accept: a transfer occurs when in_valid && in_ready. All inputs are captured only on a transfer.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Output: a transfer occurs when out_valid && out_ready. result and flags hold stable while out_valid && !out_ready.
- Legal encodings: exactly one bit set among [10:1] with [0]=0; or exactly {sub,branch} = 11'b010_0000_0001. Anything else sets illegal=1 with result=0, completes in 1 cycle, and asserts out_valid.
- States:
  - IDLE: on accept of a non-shift op, compute and go to DONE. On accept of sll/srl/sra, load working register=src_a and count=src_b[SHW-1:0]; go to SHIFT if count!=0, else DONE with result=src_a.
  - SHIFT: each cycle shift the working register by 1 (sll: <<1, zero fill; srl: >>1, zero fill; sra: >>1, sign fill) and decrement count. When count reaches 1 in this cycle, load result and go to DONE. Shift latency = shamt+1 cycles from accept to out_valid. in_ready=0 throughout.
  - DONE: out_valid=1. On out_ready, either accept a new op (back-to-back, same rules as IDLE) or return to IDLE if in_valid=0.
- Non-shift latency: out_valid rises 1 cycle after accept. Full throughput of 1 op/cycle when out_ready stays high.
- Arithmetic: add/sub use modulo 2^XLEN (carry discarded).
- slt/sltu: result = {XLEN-1 zeros, compare bit}.
- Shift amount uses only src_b[SHW-1:0]; upper bits are ignored.
- Branch: result=src_a-src_b; lt and ltu are computed from src_a/src_b directly, not from the subtraction result.
- lt and ltu are 0 for non-branch ops. zero is valid for every op.
- Flags register together with result.

Test Plan:
- Reset mid-shift: accept sll with src_a=1 and src_b=20, drop rst_n at cycle 5 -> out_valid=0 and result=0 immediately; after release, state is IDLE and in_ready=1.
- Back-to-back, out_ready=1: add(7,5), sub(3,5), and(0xF0,0x3C) on consecutive cycles -> results 12, 0xFFFFFFFE, 0x30 on 3 consecutive cycles, each 1 cycle after issue.
- Shift latency: sra src_a=0x80000000, src_b=0x24 (shamt 4) -> out_valid 5 cycles after accept, result=0xF8000000. Shamt 0 (src_b=0x20) -> 1 cycle, result=src_a.
- Branch flags: branch+sub with a=0xFFFFFFFF, b=1 -> lt=1, ltu=0, zero=0. With a=b=9 -> zero=1, lt=0, ltu=0.
- Backpressure: out_ready=0 for 4 cycles after xor(0xAA,0xFF) -> result 0x55 held stable, in_ready=0; when out_ready rises with a queued op, that op is accepted in the same cycle.
- Illegal control: alu_control=11'b100_0000_0010 -> 1 cycle later out_valid=1, illegal=1, result=0.
